// File: rtl/topk_stream_merger.sv
// rtl/topk_stream_merger.sv - streaming top-K (smallest distance) merger: beat register, per-beat sort, running merge
module topk_stream_merger #(
    parameter int DATA_WIDTH = 11,
    parameter int IDX_WIDTH  = 9,
    parameter int NUM_IN     = 8,
    parameter int K          = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_in,
    input  logic                           last_in,
    input  logic [NUM_IN-1:0]              lane_valid_in,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   data_in,
    input  logic [NUM_IN*IDX_WIDTH-1:0]    indices_in,
    output logic                           valid_out,
    output logic [K*DATA_WIDTH-1:0]        data_out,
    output logic [K*IDX_WIDTH-1:0]         indices_out,
    output logic [$clog2(K+1)-1:0]         count_out
);

    localparam int CW = $clog2(K+1);
    localparam int M  = 2 * K;

    // Stage 1: registered beat
    logic                  s1_valid, s1_last;
    logic [NUM_IN-1:0]     s1_lane;
    logic [DATA_WIDTH-1:0] s1_data [NUM_IN];
    logic [IDX_WIDTH-1:0]  s1_idx  [NUM_IN];

    // Stage 2: K best of the beat, sorted
    logic                  s2_valid, s2_last;
    logic [DATA_WIDTH-1:0] s2_data [K];
    logic [IDX_WIDTH-1:0]  s2_idx  [K];
    logic                  s2_full [K];

    // Stage 3: running accumulator
    logic [DATA_WIDTH-1:0] acc_data [K];
    logic [IDX_WIDTH-1:0]  acc_idx  [K];
    logic                  acc_full [K];

    int                    s1_rank [NUM_IN];
    logic [DATA_WIDTH-1:0] b_data  [K];
    logic [IDX_WIDTH-1:0]  b_idx   [K];
    logic                  b_full  [K];

    int                    m_rank  [M];
    logic                  m_empty [M];
    logic [DATA_WIDTH-1:0] m_data  [M];
    logic [IDX_WIDTH-1:0]  m_idx   [M];
    logic [DATA_WIDTH-1:0] mg_data [K];
    logic [IDX_WIDTH-1:0]  mg_idx  [K];
    logic                  mg_full [K];
    logic [CW-1:0]         mg_count;

    // True when entry a orders strictly before entry b; empties sort last,
    // position breaks ties so every rank in a list is unique.
    function automatic logic before_key(input logic ea, input logic [DATA_WIDTH-1:0] da, input int pa,
                                        input logic eb, input logic [DATA_WIDTH-1:0] db, input int pb);
        if (ea != eb) return eb;
        if (da != db) return da < db;
        return pa < pb;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= valid_in;
            s1_last  <= valid_in & last_in;
            if (valid_in) begin
                s1_lane <= lane_valid_in;
                for (int i = 0; i < NUM_IN; i++) begin
                    s1_data[i] <= data_in[i*DATA_WIDTH +: DATA_WIDTH];
                    s1_idx[i]  <= indices_in[i*IDX_WIDTH +: IDX_WIDTH];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            s1_rank[i] = 0;
            for (int j = 0; j < NUM_IN; j++) begin
                if (j != i && before_key(!s1_lane[j], s1_data[j], j, !s1_lane[i], s1_data[i], i))
                    s1_rank[i] = s1_rank[i] + 1;
            end
        end
        for (int s = 0; s < K; s++) begin
            b_data[s] = '1;
            b_idx[s]  = '1;
            b_full[s] = 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                if (s1_rank[i] == s && s1_lane[i]) begin
                    b_data[s] = s1_data[i];
                    b_idx[s]  = s1_idx[i];
                    b_full[s] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            if (s1_valid) begin
                s2_data <= b_data;
                s2_idx  <= b_idx;
                s2_full <= b_full;
            end
        end
    end

    // Accumulator occupies the low positions so it wins distance ties
    // against entries from the newer beat.
    always_comb begin
        for (int p = 0; p < K; p++) begin
            m_empty[p]   = !acc_full[p];
            m_data[p]    = acc_data[p];
            m_idx[p]     = acc_idx[p];
            m_empty[p+K] = !s2_full[p];
            m_data[p+K]  = s2_data[p];
            m_idx[p+K]   = s2_idx[p];
        end
        for (int a = 0; a < M; a++) begin
            m_rank[a] = 0;
            for (int b = 0; b < M; b++) begin
                if (b != a && before_key(m_empty[b], m_data[b], b, m_empty[a], m_data[a], a))
                    m_rank[a] = m_rank[a] + 1;
            end
        end
        mg_count = '0;
        for (int s = 0; s < K; s++) begin
            mg_data[s] = '1;
            mg_idx[s]  = '1;
            mg_full[s] = 1'b0;
            for (int a = 0; a < M; a++) begin
                if (m_rank[a] == s && !m_empty[a]) begin
                    mg_data[s] = m_data[a];
                    mg_idx[s]  = m_idx[a];
                    mg_full[s] = 1'b1;
                end
            end
            if (mg_full[s])
                mg_count = mg_count + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out   <= 1'b0;
            data_out    <= '1;
            indices_out <= '1;
            count_out   <= '0;
            for (int s = 0; s < K; s++) begin
                acc_data[s] <= '1;
                acc_idx[s]  <= '1;
                acc_full[s] <= 1'b0;
            end
        end else begin
            valid_out <= s2_valid & s2_last;
            if (s2_valid) begin
                if (s2_last) begin
                    for (int s = 0; s < K; s++) begin
                        data_out[s*DATA_WIDTH +: DATA_WIDTH] <= mg_data[s];
                        indices_out[s*IDX_WIDTH +: IDX_WIDTH] <= mg_idx[s];
                        acc_data[s] <= '1;
                        acc_idx[s]  <= '1;
                        acc_full[s] <= 1'b0;
                    end
                    count_out <= mg_count;
                end else begin
                    acc_data <= mg_data;
                    acc_idx  <= mg_idx;
                    acc_full <= mg_full;
                end
            end
        end
    end

endmodule
